maze_mem_arbiter: RTL and testbench
===================================

// Module: maze_mem_arbiter
// PURPOSE
//  Shares the single-port 16x16 maze memory between the host loader/viewer (H) and the rat solver controller (R).
//  Arbitrates per cycle with round-robin fairness and a host lock for bulk maze loading.
//  Pipelines accesses through a fixed 2-cycle read path.
//  Sits between the solver controller's rd_mem/wr_mem/x/y signals and the maze RAM instance.
// PARAMETERS
//  ADDR_W  8   memory address width ({y[3:0],x[3:0]} for a 16x16 maze)
//  DATA_W  1   cell width (1 = wall/visited bit)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-low reset (0 = reset asserted)
//  h_req      in   1       host access request; held, with h_wr/h_addr/h_wdata stable, until h_gnt
//  h_wr       in   1       1 = write, 0 = read
//  h_addr     in   ADDR_W  host address
//  h_wdata    in   DATA_W  host write data
//  h_lock     in   1       host exclusive mode; while 1, rat is never granted
//  h_gnt      out  1       host request accepted this cycle (combinational)
//  h_rvalid   out  1       host read data valid (1-cycle pulse)
//  h_rdata    out  DATA_W  host read data
//  r_req, r_wr, r_addr, r_wdata, r_gnt, r_rvalid, r_rdata   same as h_* for rat port
//  mem_en     out  1       memory enable (registered)
//  mem_we     out  1       memory write enable (registered)
//  mem_addr   out  ADDR_W  memory address (registered)
//  mem_din    out  DATA_W  memory write data (registered)
//  mem_dout   in   DATA_W  memory read data, valid the cycle after mem_en (synchronous RAM)
//  busy       out  1       any access in flight (stage1 or stage2 valid)
//  conflict_cnt out 16     both-requesting cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: all outputs 0; rr_ptr = HOST; both pipeline stages invalid; conflict_cnt = 0.
//  - Reset mid-operation: in-flight accesses are dropped; no rvalid is issued for them afterwards.
//  - Cycle N (accept): winner's gnt = 1. The command {wr, addr, wdata, tag} is registered into stage1 at posedge.
//  - Cycle N+1 (issue): mem_en = 1, and mem_we/addr/din come from stage1. Stage1 tag is copied to stage2 when the access is a read.
//  - Cycle N+2 (return): rvalid of the tagged port = 1, with rdata = mem_dout. The other port's rvalid = 0.
//  - Read latency is 2 cycles from gnt. Writes produce no rvalid.
//  - Throughput is one accept per cycle with no bubbles. Accesses reach memory in grant order, so read-after-write returns the new value.
//  - Arbitration FSM ARB = {IDLE, HOST_ONLY, RAT_ONLY, RR, LOCKED}, evaluated combinationally each cycle:
//      LOCKED    when h_lock = 1: only the host may be granted; r_gnt = 0 even if r_req = 1.
//      IDLE      when no request: no gnt, and stage1 is invalid next cycle.
//      HOST_ONLY / RAT_ONLY  when one requester: that requester is granted.
//      RR        when both request: grant the port rr_ptr points to.
//  - rr_ptr: after any grant, points to the non-granted port. Under continuous contention, grants alternate H, R, H, R...
//  - h_lock 1->0 while r_req pending: the rat is granted in the first cycle with h_lock = 0.
//  - h_gnt and r_gnt are never 1 in the same cycle. A gnt is never asserted without its req.
//  - Dropping req before gnt withdraws the request. This is legal; no access occurs.
// CONFIGURATION
//  MAZE_ARB_STATS_EN defined:
//  - conflict_cnt increments each cycle in which h_req & r_req & ~h_lock.
//  - The counter saturates at 16'hFFFF and is cleared by reset.
//  MAZE_ARB_STATS_EN undefined:
//  - The counter logic is not built and conflict_cnt is tied to 0.
//  - All other behaviour is identical.
// TESTING
//  1. Reset: rst = 0 mid-read (stage1 valid) -> all outputs 0; after rst = 1, no rvalid appears for the dropped read.
//  2. Single host write then read:
//     - write addr 8'h35, data 1; then read 8'h35.
//     - Expect h_gnt at N and N+1; mem_we = 1 at N+1; h_rvalid = 1 with h_rdata = 1 at N+3.
//  3. Contention: h_req = r_req = 1 held, both reads, for 6 cycles.
//     - Expect gnt order H, R, H, R, H, R.
//     - rvalid pulses alternate ports 2 cycles later.
//     - With MAZE_ARB_STATS_EN, conflict_cnt = 6.
//  4. Lock: h_lock = 1, r_req = 1 for 10 cycles.
//     - Expect r_gnt = 0 throughout.
//     - Drop h_lock -> r_gnt = 1 in that same cycle; r_rvalid 2 cycles later.
//  5. Read-after-write across ports: rat writes 8'h00 = 1, host reads 8'h00 next cycle -> h_rdata = 1.
//  6. Back-to-back rat reads of 4 distinct addresses, preloaded with 1, 0, 1, 1.
//     - Expect r_rvalid high for 4 consecutive cycles, with r_rdata = 1, 0, 1, 1.

Source files
------------

// File: rtl/maze_mem_arbiter_if.sv
// Requester-side bus of the maze memory arbiter: one instance per port (host, rat).
// master = requester (drives req/wr/addr/wdata), slave = arbiter (drives gnt/rvalid/rdata).
interface maze_mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 1
);
   logic              req;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, wr, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, wr, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/maze_mem_arbiter.sv
// Maze memory arbiter: shares one synchronous single-port RAM between host (h) and rat solver (r).
// Per-cycle grant (lock > single requester > round robin), fixed 2-cycle read path.
// Optional feature macro: MAZE_ARB_STATS_EN builds the saturating contention counter;
// without it conflict_cnt is tied to zero.
module maze_mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              rst,
   maze_mem_arbiter_if.slave h,
   maze_mem_arbiter_if.slave r,
   input  logic              h_lock,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy,
   output logic [15:0]       conflict_cnt
);
   typedef enum logic [2:0] {IDLE, HOST_ONLY, RAT_ONLY, RR, LOCKED} arb_t;
   typedef enum logic {HOST = 1'b0, RAT = 1'b1} port_t;

   arb_t              arb;
   port_t             rr_ptr;
   logic              h_win, r_win, acc;
   logic              acc_wr;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              s1_tag;      // stage1 valid/cmd live in the registered mem_* outputs
   logic              s2_vld, s2_tag;

   // Arbitration decision for this cycle; grants are suppressed while in reset.
   always_comb begin
      arb = IDLE;
      if (h_lock)                arb = LOCKED;
      else if (h.req && r.req)   arb = RR;
      else if (h.req)            arb = HOST_ONLY;
      else if (r.req)            arb = RAT_ONLY;
      h_win = 1'b0;
      r_win = 1'b0;
      case (arb)
         LOCKED:    h_win = h.req;
         HOST_ONLY: h_win = 1'b1;
         RAT_ONLY:  r_win = 1'b1;
         RR: begin
            h_win = (rr_ptr == HOST);
            r_win = (rr_ptr == RAT);
         end
         default: ;
      endcase
      h_win = h_win & rst;
      r_win = r_win & rst;
   end

   assign h.gnt     = h_win;
   assign r.gnt     = r_win;
   assign acc       = h_win | r_win;
   assign acc_wr    = h_win ? h.wr    : r.wr;
   assign acc_addr  = h_win ? h.addr  : r.addr;
   assign acc_wdata = h_win ? h.wdata : r.wdata;

   // Stage1: register the winning command straight onto the memory port; advance rr pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         s1_tag   <= 1'b0;
         rr_ptr   <= HOST;
      end else begin
         mem_en <= acc;
         mem_we <= acc & acc_wr;
         if (acc) begin
            mem_addr <= acc_addr;
            mem_din  <= acc_wdata;
            s1_tag   <= r_win;
         end
         if (h_win)      rr_ptr <= RAT;
         else if (r_win) rr_ptr <= HOST;
      end
   end

   // Stage2: only reads carry forward; the tag steers the returning RAM data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_vld <= 1'b0;
         s2_tag <= 1'b0;
      end else begin
         s2_vld <= mem_en & ~mem_we;
         s2_tag <= s1_tag;
      end
   end

   assign h.rvalid = s2_vld & ~s2_tag;
   assign r.rvalid = s2_vld &  s2_tag;
   assign h.rdata  = h.rvalid ? mem_dout : '0;
   assign r.rdata  = r.rvalid ? mem_dout : '0;
   assign busy     = mem_en | s2_vld;

`ifdef MAZE_ARB_STATS_EN
   // Count cycles where both ports contend (lock excluded), saturating at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         conflict_cnt <= '0;
      else if (h.req && r.req && !h_lock && conflict_cnt != 16'hFFFF)
         conflict_cnt <= conflict_cnt + 16'd1;
   end
`else
   assign conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Self-checking bench for maze_mem_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a grant-order memory/return-queue model.
module tb_maze_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        h_lock;
   logic        mem_en, mem_we, busy;
   logic [7:0]  mem_addr;
   logic [0:0]  mem_din, mem_dout;
   logic [15:0] conflict_cnt;

   maze_mem_arbiter_if hif ();
   maze_mem_arbiter_if rif ();

   maze_mem_arbiter dut (
      .clk(clk), .rst(rst), .h(hif), .r(rif), .h_lock(h_lock),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .busy(busy), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Synchronous single-port RAM the arbiter drives.
   logic [0:0] ram [256];
   initial for (int i = 0; i < 256; i++) ram[i] <= 1'b0;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_din;
         else        mem_dout      <= ram[mem_addr];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: grants from the priority rules, memory contents in grant order,
   // read returns queued with their due cycle.
   typedef struct {logic port; logic data; int due;} ret_t;
   ret_t       q[$];
   logic [0:0] gold [256];
   logic       pref_rat;
   logic       p_acc, p_wr;
   logic [7:0] p_addr;
   logic [0:0] p_wd;
   int         cnt_m;
   initial for (int i = 0; i < 256; i++) gold[i] = 1'b0;

   // Single compare process: every cycle, outputs vs. model.
   always @(negedge clk) begin
      logic eh, er, ehv, erv, ed;
      ret_t t;
      if (!rst) begin
         q.delete();
         pref_rat = 1'b0; p_acc = 1'b0; p_wr = 1'b0; p_addr = '0; p_wd = '0; cnt_m = 0;
         chk("rst_h_gnt", {15'd0, hif.gnt}, 16'd0);
         chk("rst_r_gnt", {15'd0, rif.gnt}, 16'd0);
         chk("rst_mem_en", {15'd0, mem_en}, 16'd0);
         chk("rst_mem_we", {15'd0, mem_we}, 16'd0);
         chk("rst_mem_addr", {8'd0, mem_addr}, 16'd0);
         chk("rst_rvalid", {14'd0, hif.rvalid, rif.rvalid}, 16'd0);
         chk("rst_rdata", {14'd0, hif.rdata, rif.rdata}, 16'd0);
         chk("rst_busy", {15'd0, busy}, 16'd0);
         chk("rst_cnt", conflict_cnt, 16'd0);
      end else begin
         eh = hif.req && (h_lock || !rif.req || !pref_rat);
         er = rif.req && !h_lock && (!hif.req || pref_rat);
         chk("h_gnt", {15'd0, hif.gnt}, {15'd0, eh});
         chk("r_gnt", {15'd0, rif.gnt}, {15'd0, er});
         chk("mem_en", {15'd0, mem_en}, {15'd0, p_acc});
         chk("mem_we", {15'd0, mem_we}, {15'd0, p_acc & p_wr});
         if (p_acc) begin
            chk("mem_addr", {8'd0, mem_addr}, {8'd0, p_addr});
            chk("mem_din", {15'd0, mem_din}, {15'd0, p_wd});
         end
         ehv = 1'b0; erv = 1'b0; ed = 1'b0;
         if (q.size() > 0 && q[0].due == cyc) begin
            t = q.pop_front();
            ehv = !t.port; erv = t.port; ed = t.data;
         end
         chk("h_rvalid", {15'd0, hif.rvalid}, {15'd0, ehv});
         chk("r_rvalid", {15'd0, rif.rvalid}, {15'd0, erv});
         chk("h_rdata", {15'd0, hif.rdata}, {15'd0, ehv & ed});
         chk("r_rdata", {15'd0, rif.rdata}, {15'd0, erv & ed});
         chk("busy", {15'd0, busy}, {15'd0, p_acc | ehv | erv});
`ifdef MAZE_ARB_STATS_EN
         chk("conflict_cnt", conflict_cnt, cnt_m[15:0]);
`else
         chk("conflict_cnt", conflict_cnt, 16'd0);
`endif
         if (hif.req && rif.req && !h_lock && cnt_m < 16'hFFFF) cnt_m++;
         p_acc = eh | er;
         p_wr = eh ? hif.wr : rif.wr;
         p_addr = eh ? hif.addr : rif.addr;
         p_wd = eh ? hif.wdata : rif.wdata;
         if (p_acc) begin
            if (p_wr) gold[p_addr] = p_wd;
            else q.push_back('{port: er, data: gold[p_addr][0], due: cyc + 2});
         end
         if (eh) pref_rat = 1'b1;
         else if (er) pref_rat = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      hif.req = 1'b0; rif.req = 1'b0; h_lock = 1'b0;
   endtask

   task automatic reset_pulse();
      tick(); rst = 1'b0; tick(); tick(); rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:0] pat [4];
      logic hs, rs;
      rst = 1'b0; h_lock = 1'b0;
      hif.req = 0; hif.wr = 0; hif.addr = 0; hif.wdata = 0;
      rif.req = 0; rif.wr = 0; rif.addr = 0; rif.wdata = 0;
      tick(); tick(); rst = 1'b1;
      tick();

      // 1: reset mid-read drops the access
      hif.req = 1; hif.wr = 0; hif.addr = 8'h12;
      @(negedge clk); chk("t1_gnt", {15'd0, hif.gnt}, 16'd1);
      tick(); rst = 1'b0;                   // stage1 holds the read now; h_req still high
      @(negedge clk);
      chk("t1_rst_gnt", {15'd0, hif.gnt}, 16'd0);
      chk("t1_rst_en", {15'd0, mem_en}, 16'd0);
      chk("t1_rst_busy", {15'd0, busy}, 16'd0);
      tick(); idle(); tick(); rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("t1_no_rvalid", {15'd0, hif.rvalid}, 16'd0);
         tick();
      end

      // 2: host write 0x35=1 then read it back
      hif.req = 1; hif.wr = 1; hif.addr = 8'h35; hif.wdata = 1;
      @(negedge clk); chk("t2_gnt_n", {15'd0, hif.gnt}, 16'd1);
      tick(); hif.wr = 0;
      @(negedge clk);
      chk("t2_gnt_n1", {15'd0, hif.gnt}, 16'd1);
      chk("t2_we_n1", {15'd0, mem_we}, 16'd1);
      chk("t2_addr_n1", {8'd0, mem_addr}, 16'h35);
      tick(); hif.req = 0;
      @(negedge clk); chk("t2_rvalid_n2", {15'd0, hif.rvalid}, 16'd0);
      tick();
      @(negedge clk);
      chk("t2_rvalid_n3", {15'd0, hif.rvalid}, 16'd1);
      chk("t2_rdata_n3", {15'd0, hif.rdata}, 16'd1);

      // 3: six cycles of contention, both reads
      reset_pulse();
      for (int i = 0; i < 8; i++) begin
         hif.req = (i < 6); hif.wr = 0; hif.addr = 8'h35;
         rif.req = (i < 6); rif.wr = 0; rif.addr = 8'h36;
         @(negedge clk);
         if (i < 6) begin
            chk("t3_h_gnt", {15'd0, hif.gnt}, (i % 2 == 0) ? 16'd1 : 16'd0);
            chk("t3_r_gnt", {15'd0, rif.gnt}, (i % 2 == 1) ? 16'd1 : 16'd0);
         end
         if (i >= 2) begin
            chk("t3_h_rvalid", {15'd0, hif.rvalid}, (i % 2 == 0) ? 16'd1 : 16'd0);
            chk("t3_r_rvalid", {15'd0, rif.rvalid}, (i % 2 == 1) ? 16'd1 : 16'd0);
            chk("t3_h_rdata", {15'd0, hif.rdata}, (i % 2 == 0) ? 16'd1 : 16'd0);
         end
`ifdef MAZE_ARB_STATS_EN
         if (i == 6) chk("t3_conflict", conflict_cnt, 16'd6);
`else
         if (i == 6) chk("t3_conflict", conflict_cnt, 16'd0);
`endif
         tick();
      end

      // 4: lock starves the rat; release grants it in that same cycle
      h_lock = 1; rif.req = 1; rif.wr = 0; rif.addr = 8'h35;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); chk("t4_locked_r_gnt", {15'd0, rif.gnt}, 16'd0);
         tick();
      end
      h_lock = 0;
      @(negedge clk); chk("t4_unlock_r_gnt", {15'd0, rif.gnt}, 16'd1);
      tick(); rif.req = 0;
      tick();
      @(negedge clk);
      chk("t4_r_rvalid", {15'd0, rif.rvalid}, 16'd1);
      chk("t4_r_rdata", {15'd0, rif.rdata}, 16'd1);
      tick();

      // 5: rat writes 0x00=1, host reads 0x00 the next cycle
      rif.req = 1; rif.wr = 1; rif.addr = 8'h00; rif.wdata = 1;
      @(negedge clk); chk("t5_r_gnt", {15'd0, rif.gnt}, 16'd1);
      tick(); rif.req = 0; hif.req = 1; hif.wr = 0; hif.addr = 8'h00;
      @(negedge clk); chk("t5_h_gnt", {15'd0, hif.gnt}, 16'd1);
      tick(); hif.req = 0;
      tick();
      @(negedge clk);
      chk("t5_h_rvalid", {15'd0, hif.rvalid}, 16'd1);
      chk("t5_h_rdata", {15'd0, hif.rdata}, 16'd1);
      tick();

      // 6: preload 0x40..0x43 = 1,0,1,1 then four back-to-back rat reads
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rif.req = 1; rif.wr = 1; rif.addr = 8'h40 + 8'(i); rif.wdata = pat[i];
         tick();
      end
      for (int i = 0; i < 7; i++) begin
         rif.req = (i < 4); rif.wr = 0; rif.addr = 8'h40 + 8'(i);
         @(negedge clk);
         if (i < 4) chk("t6_r_gnt", {15'd0, rif.gnt}, 16'd1);
         if (i >= 2 && i < 6) begin
            chk("t6_r_rvalid", {15'd0, rif.rvalid}, 16'd1);
            chk("t6_r_rdata", {15'd0, rif.rdata}, {15'd0, pat[i-2]});
         end
         if (i == 6) chk("t6_r_rvalid_end", {15'd0, rif.rvalid}, 16'd0);
         tick();
      end

      // Randomized traffic on a small address window so hazards are frequent
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); hs = hif.gnt; rs = rif.gnt;
         tick();
         if (!hif.req || hs || $urandom_range(15) == 0) begin
            hif.req = ($urandom_range(2) != 0); hif.wr = 1'($urandom_range(1));
            hif.addr = 8'($urandom_range(7)); hif.wdata = 1'($urandom_range(1));
         end
         if (!rif.req || rs || $urandom_range(15) == 0) begin
            rif.req = ($urandom_range(2) != 0); rif.wr = 1'($urandom_range(1));
            rif.addr = 8'($urandom_range(7)); rif.wdata = 1'($urandom_range(1));
         end
         if ($urandom_range(19) == 0) h_lock = !h_lock;
         if (i == 1500) rst = 1'b0;
         if (i == 1502) rst = 1'b1;
      end
      idle();
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
